// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin shared write port onto a W-bit JK flip-flop bank.
// Optional pairwise command-overlap detection is built when JK_CONFLICT_DET_EN is defined.
module jk_bank_arbiter #(
  parameter int R  = 4,
  parameter int W  = 8,
  parameter int RW = $clog2(R)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [R-1:0]    req,
  input  logic [R*W-1:0]  cmd_j,
  input  logic [R*W-1:0]  cmd_k,
  output logic [R-1:0]    ack,
  output logic [W-1:0]    q,
  output logic [W-1:0]    q_bar,
  output logic            busy,
  output logic [RW-1:0]   gnt_idx,
  output logic            conflict
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] ptr_q, ptr_d;
  logic [RW-1:0] gnt_q, gnt_d;
  logic [W-1:0]  j_q, j_d;
  logic [W-1:0]  k_q, k_d;
  logic [W-1:0]  q_q, q_d;
  logic [R-1:0]  ack_q, ack_d;

  logic [R-1:0]  mask;
  logic [R-1:0]  elig;
  logic          found;
  logic [RW-1:0] pick;
  int            cand;

  // The just-acked requester is blocked for its ack cycle only.
  always_comb begin : rr_pick
    mask  = (state_q == IDLE) ? ack_q : '0;
    elig  = req & ~mask;
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int off = 0; off < R; off++) begin
      cand = int'(ptr_q) + off;
      if (cand >= R) begin
        cand = cand - R;
      end
      if (!found && elig[RW'(cand)]) begin
        found = 1'b1;
        pick  = RW'(cand);
      end
    end
  end

  always_comb begin : fsm
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    j_d     = j_q;
    k_d     = k_q;
    q_d     = q_q;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = pick;
          j_d     = cmd_j[pick*W +: W];
          k_d     = cmd_k[pick*W +: W];
        end
      end
      GRANT: begin
        state_d = APPLY;
      end
      APPLY: begin
        q_d          = (j_q & ~q_q) | (~k_q & q_q);
        ack_d[gnt_q] = 1'b1;
        ptr_d        = (gnt_q == RW'(R-1)) ? '0 : gnt_q + 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      q_q     <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      q_q     <= q_d;
      ack_q   <= ack_d;
    end
  end

  assign q       = q_q;
  assign q_bar   = ~q_q;
  assign ack     = ack_q;
  assign busy    = (state_q == GRANT) || (state_q == APPLY);
  assign gnt_idx = gnt_q;

`ifdef JK_CONFLICT_DET_EN
  logic conflict_q, conflict_d;

  // Any two contenders touching a common bit, regardless of who wins.
  always_comb begin : conf_det
    conflict_d = conflict_q;
    if (state_q == IDLE) begin
      for (int a = 0; a < R; a++) begin
        for (int b = a + 1; b < R; b++) begin
          if (elig[a] && elig[b] &&
              |((cmd_j[a*W +: W] | cmd_k[a*W +: W]) &
                (cmd_j[b*W +: W] | cmd_k[b*W +: W]))) begin
            conflict_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict = conflict_q;
`else
  assign conflict = 1'b0;
`endif

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Owns a W-bit bank of JK flip-flops and shares write access to it among R requesters.
- Each requester presents per-bit J and K vectors with a req/ack handshake.
- A round-robin arbiter grants one requester at a time, and a 3-state sequencer applies the latched J/K command to the whole bank.
- Sits between control agents (counters, mode FSMs) and shared status/flag state that several agents must set, clear or toggle.

Parameters:
- R, 4, number of requesters (2..8).
- W, 8, bank width in bits (1..32).
- RW, $clog2(R), width of grant index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req  input  R  per-requester request; held with its command until ack.
- cmd_j  input  R*W  J vectors; requester i uses bits [i*W +: W].
- cmd_k  input  R*W  K vectors; same packing as cmd_j.
- ack  output  R  one-hot, one-cycle completion pulse.
- q  output  W  bank state.
- q_bar  output  W  complement of bank state.
- busy  output  1  high while in GRANT or APPLY.
- gnt_idx  output  RW  index of the last/current granted requester.
- conflict  output  1  sticky conflict flag (only with the optional feature; tied 0 otherwise).

Behaviour:
- Reset (async, rst=1):
  - q=0, q_bar=all ones, ack=0, busy=0, gnt_idx=0, conflict=0.
  - Round-robin pointer ptr=0, state=IDLE, latched J/K=0.
- States: IDLE, GRANT, APPLY; clean encoding, no illegal-state lockup (any unused encoding returns to IDLE).
- IDLE:
  - Form eligible = req & ~mask.
  - If eligible is nonzero, pick the first set bit searching ptr, ptr+1, … (mod R).
  - Register that index into gnt_idx, latch its cmd_j/cmd_k slices, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: busy=1; go to APPLY. Command lines are not re-sampled.
- APPLY:
  - busy=1; on this edge each bank bit n updates per the latched j[n], k[n]:
    - 00 = hold.
    - 01 = q 0.
    - 10 = q 1.
    - 11 = toggle.
  - q_bar[n] is always updated to ~(new q[n]).
  - Same edge: ack[gnt_idx]=1, ptr = (gnt_idx+1) mod R, state → IDLE.
- ack is high for exactly the one cycle following the APPLY edge; all other ack bits stay 0.
- Latency: req sampled in IDLE at edge T → q updated at edge T+2, ack visible T+2..T+3.
  - Throughput: at most one command per 3 cycles.
- Double-service guard:
  - mask = the one-hot of the just-acked requester, valid only during the single IDLE cycle in which ack is high; otherwise mask=0.
  - The requester must drop req by the end of the ack cycle; req still high afterwards is a new request.
- Fairness: a requester holding req is granted within R transactions.
- Simultaneous requests: only the winner is served; losers keep req high and are served in ptr order.
- req dropping after being latched: the command still completes and ack still pulses.
- Invariant q_bar == ~q holds every cycle, including out of reset.
- Reset mid-transaction: the transaction is abandoned with no ack and no bank update after rst rises; all state returns to reset values.

Optional Feature:
- Macro JK_CONFLICT_DET_EN.
- Defined:
  - In IDLE, when ≥2 eligible requesters exist and any two of them have overlapping non-hold bits ((j|k) vectors AND nonzero), set conflict=1.
  - conflict stays sticky until rst; it does not alter arbitration.
- Undefined: no detection logic; conflict tied to 0.

Test Plan:
- Reset: assert rst mid-cycle with q=8'hA5 → q=8'h00, q_bar=8'hFF, ack=0, busy=0 immediately, without a clock edge.
- Single requester 0:
  - j=8'h0F, k=8'h00 → q=8'h0F two edges after the sample, ack=4'b0001 for one cycle.
  - Then j=k=8'hFF → q=8'hF0, q_bar=8'h0F.
- All four req high at once, each with a distinct set pattern:
  - Grants occur in order 0,1,2,3.
  - The next round starting with req 1 and 3 high grants 1 then 3.
- Requester 2 holds req after ack:
  - Masked only in the ack cycle, then re-granted.
  - Exactly one ack per 3-cycle transaction, never two in consecutive cycles.
- rst pulse during APPLY of a j=8'hFF command → no ack, q=0, next grant starts from ptr=0.
- JK_CONFLICT_DET_EN defined:
  - req0 j=8'h01 and req1 k=8'h01 simultaneously → conflict=1 and stays 1.
  - Disjoint masks 8'h01/8'h02 → conflict stays 0.
